// File: rtl/iiitb_wm_pkg.sv
// Washing-machine controller package.
// Holds the controller state enum (3-bit encoding), the actuator bundle type
// and small decode helpers shared by the controller and its timer user logic.
package iiitb_wm_pkg;

    // Width of the rinse_idx output (rinse passes completed).
    localparam int unsigned RinseIdxW = 3;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFill      = 3'd1,
        StDetergent = 3'd2,
        StWash      = 3'd3,
        StDrain     = 3'd4,
        StSpin      = 3'd5,
        StDone      = 3'd6,
        StFault     = 3'd7
    } wm_state_e;

    typedef struct packed {
        logic door_lock;
        logic motor_on;
        logic fill_valve_on;
        logic drain_valve_on;
    } wm_act_t;

    // Actuator levels that belong to a given state.
    function automatic wm_act_t wm_act_decode(wm_state_e st);
        wm_act_t act;
        act = '0;
        case (st)
            StFill: begin
                act.door_lock     = 1'b1;
                act.fill_valve_on = 1'b1;
            end
            StDetergent: act.door_lock = 1'b1;
            StWash: begin
                act.door_lock = 1'b1;
                act.motor_on  = 1'b1;
            end
            StDrain: begin
                act.door_lock      = 1'b1;
                act.drain_valve_on = 1'b1;
            end
            StSpin: begin
                act.door_lock      = 1'b1;
                act.motor_on       = 1'b1;
                act.drain_valve_on = 1'b1;
            end
            StFault: act.door_lock = 1'b1;
            default: act = '0;
        endcase
        return act;
    endfunction

    // States that wait on a sensor and are guarded by the watchdog.
    function automatic logic wm_is_watched(wm_state_e st);
        return (st == StFill) || (st == StDetergent) || (st == StDrain);
    endfunction

endpackage

// File: rtl/iiitb_wm_ctrl_if.sv
// Washing-machine controller signal bundle.
// Sensor/user inputs: door_close, start, filled, detergent_added, drained.
// Outputs: door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
//          water_wash, done, fault, rinse_idx[2:0].
// slave modport is the controller side, master modport the machine/user side.
interface iiitb_wm_ctrl_if;
    logic       door_close;
    logic       start;
    logic       filled;
    logic       detergent_added;
    logic       drained;
    logic       door_lock;
    logic       motor_on;
    logic       fill_valve_on;
    logic       drain_valve_on;
    logic       soap_wash;
    logic       water_wash;
    logic       done;
    logic       fault;
    logic [2:0] rinse_idx;

    modport slave (
        input  door_close, start, filled, detergent_added, drained,
        output door_lock, motor_on, fill_valve_on, drain_valve_on,
        output soap_wash, water_wash, done, fault, rinse_idx
    );

    modport master (
        output door_close, start, filled, detergent_added, drained,
        input  door_lock, motor_on, fill_valve_on, drain_valve_on,
        input  soap_wash, water_wash, done, fault, rinse_idx
    );
endinterface

// File: rtl/iiitb_wm_timer.sv
// Loadable CNT_W-bit down-counter used for phase timing and the watchdog.
// Ports: clk_i, rst_ni (async active-low), load_i/load_val_i (load count),
//        expired_o (high in the last cycle of the loaded interval).
module iiitb_wm_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N yields N cycles: the count reads N..1, and 1 marks the last.
    assign expired_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/iiitb_wm_ctrl.sv
// Washing-machine controller: soap pass, N_RINSE rinse passes, final spin.
// Ports: clk, reset (async active-low), wm (iiitb_wm_ctrl_if.slave bundle).
// All outputs are registered and decoded from the next state (Moore).
// Optional feature: define WM_WDOG_EN to enable the fill/detergent/drain
// watchdog and the sticky FAULT state; otherwise those states wait forever
// and fault is tied low.
module iiitb_wm_ctrl
    import iiitb_wm_pkg::*;
#(
    parameter int unsigned N_RINSE     = 2,
    parameter int unsigned WASH_TICKS  = 16,
    parameter int unsigned RINSE_TICKS = 8,
    parameter int unsigned SPIN_TICKS  = 12,
    parameter int unsigned WDOG_TICKS  = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    iiitb_wm_ctrl_if.slave wm
);

`ifdef WM_WDOG_EN
    localparam bit WdogEn = 1'b1;
`else
    localparam bit WdogEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0]     WashTicks  = CNT_W'(WASH_TICKS);
    localparam logic [CNT_W-1:0]     RinseTicks = CNT_W'(RINSE_TICKS);
    localparam logic [CNT_W-1:0]     SpinTicks  = CNT_W'(SPIN_TICKS);
    localparam logic [CNT_W-1:0]     WdogTicks  = CNT_W'(WDOG_TICKS);
    localparam logic [RinseIdxW-1:0] RinseMax   = RinseIdxW'(N_RINSE);

    wm_state_e            state_q, state_d;
    logic                 soap_pass_q, soap_pass_d;
    logic [RinseIdxW-1:0] rinse_idx_q, rinse_idx_d;
    wm_act_t              act_q, act_d;
    logic                 soap_wash_q, soap_wash_d;
    logic                 water_wash_q, water_wash_d;
    logic                 done_q, done_d;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_load_val;
    logic                 tmr_expired;
    logic                 wdog_trip;

    iiitb_wm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .expired_o  (tmr_expired)
    );

    // Only sensor-wait states load the watchdog interval, so expiry there is a timeout.
    assign wdog_trip = WdogEn && wm_is_watched(state_q) && tmr_expired;

    // Next-state logic; each state looks only at the input that concerns it.
    always_comb begin
        state_d     = state_q;
        soap_pass_d = soap_pass_q;
        rinse_idx_d = rinse_idx_q;
        unique case (state_q)
            StIdle: begin
                if (wm.start && wm.door_close) begin
                    state_d     = StFill;
                    soap_pass_d = 1'b1;
                end
            end
            StFill: begin
                if (wm.filled) begin
                    state_d = soap_pass_q ? StDetergent : StWash;
                end else if (wdog_trip) begin
                    state_d = StFault;
                end
            end
            StDetergent: begin
                if (wm.detergent_added) begin
                    state_d = StWash;
                end else if (wdog_trip) begin
                    state_d = StFault;
                end
            end
            StWash: begin
                if (tmr_expired) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wm.drained) begin
                    if (!soap_pass_q) begin
                        rinse_idx_d = rinse_idx_q + RinseIdxW'(1);
                    end
                    soap_pass_d = 1'b0;
                    state_d     = (rinse_idx_d < RinseMax) ? StFill : StSpin;
                end else if (wdog_trip) begin
                    state_d = StFault;
                end
            end
            StSpin: begin
                if (tmr_expired) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d     = StIdle;
                soap_pass_d = 1'b0;
                rinse_idx_d = '0;
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    // Timer reloads on every state change with the interval of the state being entered.
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            StWash:                       tmr_load_val = soap_pass_d ? WashTicks : RinseTicks;
            StSpin:                       tmr_load_val = SpinTicks;
            StFill, StDetergent, StDrain: tmr_load_val = WdogTicks;
            default:                      tmr_load_val = '0;
        endcase
    end

    // Output decode from the next state so registered outputs align with state_q.
    always_comb begin
        act_d        = wm_act_decode(state_d);
        done_d       = (state_d == StDone);
        soap_wash_d  = soap_pass_d &&
                       (state_d inside {StFill, StDetergent, StWash, StDrain});
        // Rinse flag stays up through DONE and drops on the return to IDLE.
        water_wash_d = !soap_pass_d &&
                       (state_d inside {StFill, StWash, StDrain, StSpin, StDone});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            soap_pass_q  <= 1'b0;
            rinse_idx_q  <= '0;
            act_q        <= '0;
            soap_wash_q  <= 1'b0;
            water_wash_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            soap_pass_q  <= soap_pass_d;
            rinse_idx_q  <= rinse_idx_d;
            act_q        <= act_d;
            soap_wash_q  <= soap_wash_d;
            water_wash_q <= water_wash_d;
            done_q       <= done_d;
        end
    end

`ifdef WM_WDOG_EN
    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == StFault);
        end
    end

    assign wm.fault = fault_q;
`else
    assign wm.fault = 1'b0;
`endif

    assign wm.door_lock      = act_q.door_lock;
    assign wm.motor_on       = act_q.motor_on;
    assign wm.fill_valve_on  = act_q.fill_valve_on;
    assign wm.drain_valve_on = act_q.drain_valve_on;
    assign wm.soap_wash      = soap_wash_q;
    assign wm.water_wash     = water_wash_q;
    assign wm.done           = done_q;
    assign wm.rinse_idx      = rinse_idx_q;

endmodule
